// File: rtl/cdc_channel_mux.sv
// Multiplexes NUM_CH byte channels onto one tagged USB bulk IN stream and
// demultiplexes tagged OUT bytes back to per-channel RX registers or loopback.

module cdc_channel_mux_lane #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              loopback_i,
    input  logic              out_wr_i,
    input  logic [DATA_W-1:0] out_data_i,
    output logic              out_accept_o,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       cnt_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_vld_q;
    logic              full, push, rx_ld;
    logic [DATA_W-1:0] wdata;

    assign full         = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o      = (cnt_q == '0);
    assign head_o       = mem_q[rptr_q];
    assign in_ready_o   = !full && !loopback_i;
    // Loopback and user writes are mutually exclusive: in_ready is low in loopback.
    assign push         = (in_valid_i && in_ready_o) || (out_wr_i && loopback_i);
    assign wdata        = (out_wr_i && loopback_i) ? out_data_i : in_data_i;
    assign rx_ld        = out_wr_i && !loopback_i;
    assign out_accept_o = loopback_i ? !full : (!rx_vld_q || rx_ready_i);
    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_vld_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push)  wptr_q <= wptr_q + AW'(1);
            if (pop_i) rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_vld_q  <= 1'b0;
            rx_data_q <= '0;
        end else if (rx_ld) begin
            rx_vld_q  <= 1'b1;
            rx_data_q <= out_data_i;
        end else if (rx_ready_i) begin
            rx_vld_q  <= 1'b0;
        end
    end
endmodule

module cdc_channel_mux #(
    parameter int  NUM_CH    = 2,
    parameter int  DATA_W    = 8,
    parameter int  DEPTH     = 8,
    parameter int  MAX_BURST = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_in_data,
    input  logic [NUM_CH-1:0]        ch_in_valid,
    output logic [NUM_CH-1:0]        ch_in_ready,
    input  logic [NUM_CH-1:0]        ch_loopback,
    output logic [DATA_W-1:0]        usb_in_data,
    output logic [CH_W-1:0]          usb_in_ch,
    output logic                     usb_in_valid,
    input  logic                     usb_in_ready,
    input  logic [DATA_W-1:0]        usb_out_data,
    input  logic [CH_W-1:0]          usb_out_ch,
    input  logic                     usb_out_valid,
    output logic                     usb_out_ready,
    output logic [NUM_CH*DATA_W-1:0] ch_out_data,
    output logic [NUM_CH-1:0]        ch_out_valid,
    input  logic [NUM_CH-1:0]        ch_out_ready,
    output logic                     bad_ch
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [NUM_CH-1:0][DATA_W-1:0] heads;
    logic [NUM_CH-1:0]             empty, accept, sel, pop;
    logic                          out_fire, bad;

    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [DATA_W-1:0] in_data_q;
    logic [CH_W-1:0]   in_ch_q;
    logic              in_vld_q, bad_q;

    logic              load_ok, cont, ld, pick_vld;
    logic [CH_W-1:0]   ld_ch, pick_ch;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        cdc_channel_mux_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane (
            .clk          (clk),
            .rst          (rst),
            .in_data_i    (ch_in_data[i*DATA_W +: DATA_W]),
            .in_valid_i   (ch_in_valid[i]),
            .in_ready_o   (ch_in_ready[i]),
            .loopback_i   (ch_loopback[i]),
            .out_wr_i     (out_fire && sel[i]),
            .out_data_i   (usb_out_data),
            .out_accept_o (accept[i]),
            .pop_i        (pop[i]),
            .head_o       (heads[i]),
            .empty_o      (empty[i]),
            .rx_data_o    (ch_out_data[i*DATA_W +: DATA_W]),
            .rx_valid_o   (ch_out_valid[i]),
            .rx_ready_i   (ch_out_ready[i])
        );
    end

    // Tags that match no channel are always accepted and dropped.
    always_comb begin
        usb_out_ready = 1'b1;
        bad           = 1'b1;
        sel           = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (usb_out_ch == CH_W'(k)) begin
                usb_out_ready = accept[k];
                bad           = 1'b0;
                sel[k]        = 1'b1;
            end
        end
    end
    assign out_fire = usb_out_valid && usb_out_ready;

    // Round-robin search from grant+1; descending loop so the nearest wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_ch  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (!empty[(int'(grant_q) + k) % NUM_CH]) begin
                pick_vld = 1'b1;
                pick_ch  = CH_W'((int'(grant_q) + k) % NUM_CH);
            end
        end
    end

    assign load_ok = !in_vld_q || usb_in_ready;
    assign cont    = (state_q == S_BURST) && !empty[grant_q] && (burst_q < BW'(MAX_BURST));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        ld      = 1'b0;
        ld_ch   = grant_q;
        pop     = '0;
        if (load_ok) begin
            if (cont) begin
                ld      = 1'b1;
                burst_d = burst_q + BW'(1);
            end else if (pick_vld) begin
                ld      = 1'b1;
                ld_ch   = pick_ch;
                grant_d = pick_ch;
                burst_d = BW'(1);
                state_d = S_BURST;
            end else begin
                burst_d = '0;
                state_d = S_IDLE;
            end
        end
        if (ld) pop[ld_ch] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= CH_W'(NUM_CH - 1);
            burst_q   <= '0;
            in_vld_q  <= 1'b0;
            in_data_q <= '0;
            in_ch_q   <= '0;
            bad_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            bad_q   <= out_fire && bad;
            if (load_ok) begin
                in_vld_q <= ld;
                if (ld) begin
                    in_data_q <= heads[ld_ch];
                    in_ch_q   <= ld_ch;
                end
            end
        end
    end

    assign usb_in_valid = in_vld_q;
    assign usb_in_data  = in_data_q;
    assign usb_in_ch    = in_ch_q;
    assign bad_ch       = bad_q;
endmodule

// File: tb/tb_cdc_channel_mux.sv
// Directed bench for cdc_channel_mux; three channels so the 2-bit tag can carry
// an out-of-range value.
module tb_cdc_channel_mux;
    localparam int NC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC*8-1:0] ch_in_data;
    logic [NC-1:0] ch_in_valid, ch_in_ready, ch_loopback;
    logic [7:0]    usb_in_data;
    logic [1:0]    usb_in_ch;
    logic          usb_in_valid, usb_in_ready;
    logic [7:0]    usb_out_data;
    logic [1:0]    usb_out_ch;
    logic          usb_out_valid, usb_out_ready;
    logic [NC*8-1:0] ch_out_data;
    logic [NC-1:0] ch_out_valid, ch_out_ready;
    logic          bad_ch;

    int n_cmp = 0;
    int n_err = 0;

    cdc_channel_mux #(.NUM_CH(NC), .DATA_W(8), .DEPTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .ch_in_data(ch_in_data), .ch_in_valid(ch_in_valid), .ch_in_ready(ch_in_ready),
        .ch_loopback(ch_loopback),
        .usb_in_data(usb_in_data), .usb_in_ch(usb_in_ch), .usb_in_valid(usb_in_valid),
        .usb_in_ready(usb_in_ready),
        .usb_out_data(usb_out_data), .usb_out_ch(usb_out_ch), .usb_out_valid(usb_out_valid),
        .usb_out_ready(usb_out_ready),
        .ch_out_data(ch_out_data), .ch_out_valid(ch_out_valid), .ch_out_ready(ch_out_ready),
        .bad_ch(bad_ch)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ch_in_valid = '0; ch_in_data = '0; ch_loopback = '0;
        usb_out_valid = 1'b0; usb_out_data = '0; usb_out_ch = '0;
        ch_out_ready = '0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    logic [7:0] exp_d [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                               8'h04, 8'h05, 8'h14, 8'h15};
    logic [1:0] exp_c [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};

    initial begin
        int acc;
        int got_n;
        logic [7:0] got_d [4];
        logic [1:0] got_c [4];
        logic seen;

        // Reset state and single-byte latency
        usb_in_ready = 1'b1;
        do_reset();
        chk("rst_in_valid", usb_in_valid, 0);
        chk("rst_in_data", usb_in_data, 0);
        chk("rst_out_valid", ch_out_valid, 0);
        chk("rst_bad", bad_ch, 0);
        chk("rst_in_ready", ch_in_ready, 3'b111);
        ch_in_data[7:0] = 8'h41; ch_in_valid = 3'b001;
        step();
        ch_in_valid = '0;
        chk("lat_c1_valid", usb_in_valid, 0);
        step();
        chk("lat_c2_valid", usb_in_valid, 1);
        chk("lat_c2_data", usb_in_data, 8'h41);
        chk("lat_c2_ch", usb_in_ch, 0);
        step();
        chk("lat_one_beat", usb_in_valid, 0);

        // Round-robin bursts across two preloaded channels
        usb_in_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            ch_in_data[7:0]  = 8'(k);
            ch_in_data[15:8] = 8'(8'h10 + k);
            ch_in_valid = 3'b011;
            step();
        end
        ch_in_valid = '0;
        step();
        usb_in_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            chk("rr_valid", usb_in_valid, 1);
            chk("rr_data", usb_in_data, exp_d[j]);
            chk("rr_ch", usb_in_ch, exp_c[j]);
            step();
        end
        chk("rr_done", usb_in_valid, 0);

        // FIFO fills to DEPTH behind an occupied output register
        usb_in_ready = 1'b0;
        do_reset();
        ch_in_data[7:0] = 8'h99; ch_in_valid = 3'b001;
        step();
        ch_in_valid = '0;
        step();
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            logic r;
            ch_in_data[15:8] = 8'(8'h20 + acc);
            ch_in_valid = 3'b010;
            r = ch_in_ready[1];
            step();
            if (r) acc++;
        end
        ch_in_valid = '0;
        chk("full_count", acc, 8);
        chk("full_ready", ch_in_ready[1], 0);
        usb_in_ready = 1'b1;
        chk("full_d0", usb_in_data, 8'h99);
        chk("full_c0", usb_in_ch, 0);
        step();
        for (int j = 0; j < 8; j++) begin
            chk("full_valid", usb_in_valid, 1);
            chk("full_data", usb_in_data, 8'(8'h20 + j));
            chk("full_ch", usb_in_ch, 1);
            step();
        end
        chk("full_done", usb_in_valid, 0);

        // Loopback on channel 1
        usb_in_ready = 1'b1;
        do_reset();
        ch_loopback = 3'b010;
        #1;
        chk("lb_in_ready", ch_in_ready[1], 0);
        usb_out_valid = 1'b1; usb_out_ch = 2'd1; usb_out_data = 8'hAA;
        chk("lb_out_ready", usb_out_ready, 1);
        step();
        usb_out_data = 8'hBB;
        step();
        usb_out_valid = 1'b0;
        got_n = 0;
        for (int k = 0; k < 10; k++) begin
            if (usb_in_valid && got_n < 4) begin
                got_d[got_n] = usb_in_data;
                got_c[got_n] = usb_in_ch;
                got_n++;
            end
            step();
        end
        chk("lb_count", got_n, 2);
        chk("lb_d0", got_d[0], 8'hAA);
        chk("lb_c0", got_c[0], 1);
        chk("lb_d1", got_d[1], 8'hBB);
        chk("lb_c1", got_c[1], 1);
        chk("lb_rx_valid", ch_out_valid[1], 0);

        // RX register backpressure and out-of-range tag
        do_reset();
        usb_out_valid = 1'b1; usb_out_ch = 2'd0; usb_out_data = 8'h55;
        chk("rx_rdy0", usb_out_ready, 1);
        step();
        chk("rx_valid0", ch_out_valid[0], 1);
        chk("rx_data0", ch_out_data[7:0], 8'h55);
        usb_out_data = 8'h66;
        chk("rx_block", usb_out_ready, 0);
        step();
        chk("rx_block2", usb_out_ready, 0);
        chk("rx_hold", ch_out_data[7:0], 8'h55);
        ch_out_ready[0] = 1'b1;
        #1;
        chk("rx_release", usb_out_ready, 1);
        step();
        usb_out_valid = 1'b0;
        chk("rx_data1", ch_out_data[7:0], 8'h66);
        chk("rx_valid1", ch_out_valid[0], 1);
        step();
        chk("rx_drained", ch_out_valid[0], 0);
        usb_out_valid = 1'b1; usb_out_ch = 2'd3; usb_out_data = 8'h77;
        chk("bad_rdy", usb_out_ready, 1);
        chk("bad_pre", bad_ch, 0);
        step();
        usb_out_valid = 1'b0;
        chk("bad_pulse", bad_ch, 1);
        chk("bad_no_rx", ch_out_valid, 0);
        step();
        chk("bad_clear", bad_ch, 0);

        // Reset in the middle of a burst
        usb_in_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            ch_in_data[7:0] = 8'(8'h50 + k); ch_in_valid = 3'b001;
            step();
        end
        ch_in_valid = '0;
        step();
        usb_in_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", usb_in_valid, 0);
        chk("mid_rst_ready", ch_in_ready, 3'b111);
        ch_in_data[15:8] = 8'hC1; ch_in_valid = 3'b010;
        step();
        ch_in_valid = '0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            if (usb_in_valid) begin
                seen = 1'b1;
                chk("post_rst_data", usb_in_data, 8'hC1);
                chk("post_rst_ch", usb_in_ch, 1);
            end else begin
                step();
            end
        end
        chk("post_rst_seen", seen, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
